clkgen_frac: RTL and testbench
==============================

# clkgen_frac

Multi-channel fractional clock-enable synthesiser. It generalises the fixed-ratio PLL wrappers into N runtime-programmable phase-accumulator channels, all running from one reference clock. Each channel emits a one-cycle STROBE at an average rate of Fref·INC/2^ACC_WIDTH and a ~50% duty CLKOUT level. It sits beside the PLL and drives clock enables for video, UART and timer logic. A config handshake allows retuning at runtime, and LOCK reports when all channels are settled.

## Interface
- CHANNELS, 2: number of independent channels, 1..8
- ACC_WIDTH, 24: phase accumulator width, 4..32
- INC_DEFAULT, 0: reset increments, packed CHANNELS·ACC_WIDTH; channel c = bits [c·ACC_WIDTH +: ACC_WIDTH]
- SETTLE_CYCLES, 16: LOCK-low hold after reset or reconfig, ≥1
- REFERENCECLK  in  1  sole clock, all logic rising edge
- RESET  in  1  synchronous, active-low
- CFG_VALID  in  1  config request
- CFG_READY  out  1  config accept
- CFG_CHAN  in  max(1,$clog2(CHANNELS))  target channel
- CFG_INC  in  ACC_WIDTH  new increment
- ENABLE  in  CHANNELS  per-channel run
- STROBE  out  CHANNELS  one-cycle carry pulse per channel
- CLKOUT  out  CHANNELS  accumulator MSB per channel, registered
- LOCK  out  1  high when no settle is in progress

## Operation
- Per-channel registers: acc[c] and inc[c], both ACC_WIDTH bits.
- Each cycle with ENABLE[c]=1: {carry, acc[c]} <= acc[c] + inc[c], computed at ACC_WIDTH+1 bits. STROBE[c] <= carry. CLKOUT[c] <= MSB of the new acc. Wrap is modulo 2^ACC_WIDTH.
- ENABLE[c]=0: acc[c] <= 0, STROBE[c] <= 0, CLKOUT[c] <= 0. inc[c] is retained.
- inc[c]=0: acc frozen, no strobes. inc=2^(ACC_WIDTH-1): STROBE every 2nd cycle. Maximum rate is therefore Fref/2 for a 50% pattern; any inc ≥ 2^(ACC_WIDTH-1) gives irregular strobes, which is allowed.
- FSM states: SETTLE, IDLE, APPLY.
  - SETTLE: counter runs to SETTLE_CYCLES; CFG_READY=0, LOCK=0; then → IDLE.
  - IDLE: CFG_READY=1, LOCK=1. On CFG_VALID & CFG_READY, latch CFG_CHAN/CFG_INC → APPLY.
  - APPLY (1 cycle): CFG_READY=0, LOCK=0. If CFG_CHAN < CHANNELS: inc[chan] <= latched INC, acc[chan] <= 0, STROBE[chan]/CLKOUT[chan] forced 0 this cycle, → SETTLE (counter cleared). If CFG_CHAN ≥ CHANNELS: no write, → IDLE, LOCK stays low only in the APPLY cycle.
- Non-target channels keep running undisturbed through APPLY and SETTLE.
- Only one request is accepted per handshake. CFG_VALID held high re-issues after return to IDLE.
- RESET low (sampled at edge): acc=0, inc=INC_DEFAULT, STROBE=0, CLKOUT=0, CFG_READY=0, LOCK=0, state=SETTLE, settle counter=0. RESET mid-APPLY/SETTLE aborts and discards the pending config.

## Timing
- Reset values of all outputs are 0.
- First edge with RESET high starts SETTLE. CFG_READY and LOCK rise together SETTLE_CYCLES edges later.
- Handshake: accept at edge N (VALID & READY). APPLY is cycle N+1. inc/acc are written at edge N+1. SETTLE spans SETTLE_CYCLES cycles, and READY/LOCK return high after edge N+1+SETTLE_CYCLES.
- Accumulator latency: acc starts at 0 and ENABLE rises before edge 0. Edge k computes (k+1)·inc. STROBE is high after the first edge whose add carries; e.g. inc=2^(ACC_WIDTH-2) gives a STROBE after edge 3, then every 4th edge.
- ENABLE falling at edge k: STROBE/CLKOUT are 0 after edge k.
- Throughput: at most one config per 2+SETTLE_CYCLES cycles.

## Test plan
- ACC_WIDTH=8, CHANNELS=2, INC_DEFAULT={8'h40,8'h80}, SETTLE_CYCLES=4; release reset, ENABLE=2'b11 -> LOCK/READY high 4 cycles after release; ch0 STROBE period 2, ch1 period 4 with first pulse after 4th enabled edge; CLKOUT ch1 duty 2/4.
- inc=8'h55 on ch0 for 768 cycles -> exactly 255 strobes (85/256 average), never two strobes in consecutive cycles.
- Config ch1 INC=8'h20 while ch0 runs -> READY low for 5 cycles, LOCK low for 5; ch1 acc restarts at 0 with period 8; ch0 strobe pattern unbroken.
- CFG_CHAN=3 (out of range) -> accepted, READY low exactly 1 cycle, no inc change, no SETTLE.
- Reset asserted during SETTLE after a reconfig -> inc returns to INC_DEFAULT, all outputs 0, new 4-cycle SETTLE on release.
- inc=0 and ENABLE toggling -> STROBE/CLKOUT stay 0; re-enable with inc=8'h80 -> first STROBE after 2nd edge.

Source files
------------

// File: rtl/clkgen_frac_if.sv
// Configuration handshake between a controller and the fractional clock-enable generator.
// The controller offers a channel index and a new increment; the generator accepts when idle.
interface clkgen_frac_if #(
    parameter int CHANNELS  = 2,
    parameter int ACC_WIDTH = 24
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                 CFG_VALID;
    logic                 CFG_READY;
    logic [CHAN_W-1:0]    CFG_CHAN;
    logic [ACC_WIDTH-1:0] CFG_INC;

    modport master (
        output CFG_VALID,
        output CFG_CHAN,
        output CFG_INC,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID,
        input  CFG_CHAN,
        input  CFG_INC,
        output CFG_READY
    );
endinterface

// File: rtl/clkgen_frac.sv
// Multi-channel phase-accumulator clock-enable generator with runtime retuning.
// Each channel emits a carry strobe and an MSB clock level; LOCK drops while a retune settles.
module clkgen_frac #(
    parameter int                             CHANNELS      = 2,
    parameter int                             ACC_WIDTH     = 24,
    parameter logic [CHANNELS*ACC_WIDTH-1:0]  INC_DEFAULT   = '0,
    parameter int                             SETTLE_CYCLES = 16
) (
    input  logic                REFERENCECLK,
    input  logic                RESET,
    clkgen_frac_if.slave        cfg,
    input  logic [CHANNELS-1:0] ENABLE,
    output logic [CHANNELS-1:0] STROBE,
    output logic [CHANNELS-1:0] CLKOUT,
    output logic                LOCK
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        IDLE   = 2'd1,
        APPLY  = 2'd2
    } state_e;

    state_e                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [CHAN_W-1:0]                  chan_q, chan_d;
    logic [ACC_WIDTH-1:0]               new_inc_q, new_inc_d;
    logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0][ACC_WIDTH-1:0] inc_q, inc_d;
    logic [CHANNELS-1:0]                strobe_q, strobe_d;
    logic [CHANNELS-1:0]                clkout_q, clkout_d;
    logic [ACC_WIDTH:0]                 sum;
    logic                               chan_valid;
    logic                               ready;

    // Out-of-range channel requests are accepted but write nothing and skip the settle.
    assign chan_valid = ({1'b0, chan_q} < (CHAN_W + 1)'(CHANNELS));

    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) begin
            state_q   <= SETTLE;
            cnt_q     <= '0;
            chan_q    <= '0;
            new_inc_q <= '0;
            acc_q     <= '0;
            inc_q     <= INC_DEFAULT;
            strobe_q  <= '0;
            clkout_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chan_q    <= chan_d;
            new_inc_q <= new_inc_d;
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            strobe_q  <= strobe_d;
            clkout_q  <= clkout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        new_inc_d = new_inc_q;
        case (state_q)
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (cfg.CFG_VALID) begin
                    chan_d    = cfg.CFG_CHAN;
                    new_inc_d = cfg.CFG_INC;
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                cnt_d   = '0;
                state_d = chan_valid ? SETTLE : IDLE;
            end
            default: state_d = SETTLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
    end

    assign cfg.CFG_READY = ready;
    assign LOCK          = ready;

    // The retuned channel restarts from phase zero; all other channels keep free-running.
    always_comb begin
        acc_d    = acc_q;
        inc_d    = inc_q;
        strobe_d = '0;
        clkout_d = '0;
        sum      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
            if (state_q == APPLY && chan_valid && chan_q == CHAN_W'(c)) begin
                inc_d[c]    = new_inc_q;
                acc_d[c]    = '0;
                strobe_d[c] = 1'b0;
                clkout_d[c] = 1'b0;
            end else if (ENABLE[c]) begin
                acc_d[c]    = sum[ACC_WIDTH-1:0];
                strobe_d[c] = sum[ACC_WIDTH];
                clkout_d[c] = sum[ACC_WIDTH-1];
            end else begin
                acc_d[c]    = '0;
                strobe_d[c] = 1'b0;
                clkout_d[c] = 1'b0;
            end
        end
    end

    assign STROBE = strobe_q;
    assign CLKOUT = clkout_q;
endmodule

// File: tb/tb_clkgen_frac.sv
// Bench for clkgen_frac: a cycle model feeds a scoreboard for the two-channel instance,
// and a three-channel instance exercises an out-of-range configuration request.
module tb_clkgen_frac;
    localparam int M_SETTLE = 0;
    localparam int M_IDLE   = 1;
    localparam int M_APPLY  = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] en_a;
    logic [1:0] a_strobe, a_clkout;
    logic       a_lock;
    logic [2:0] en_b;
    logic [2:0] b_strobe, b_clkout;
    logic       b_lock;

    int n_checks = 0;
    int n_fail   = 0;

    clkgen_frac_if #(.CHANNELS(2), .ACC_WIDTH(8)) a_if ();
    clkgen_frac_if #(.CHANNELS(3), .ACC_WIDTH(8)) b_if ();

    clkgen_frac #(
        .CHANNELS(2), .ACC_WIDTH(8),
        .INC_DEFAULT({8'h40, 8'h80}), .SETTLE_CYCLES(4)
    ) dut_a (
        .REFERENCECLK(clk), .RESET(rst_n), .cfg(a_if),
        .ENABLE(en_a), .STROBE(a_strobe), .CLKOUT(a_clkout), .LOCK(a_lock)
    );

    clkgen_frac #(
        .CHANNELS(3), .ACC_WIDTH(8),
        .INC_DEFAULT({8'h20, 8'h40, 8'h80}), .SETTLE_CYCLES(4)
    ) dut_b (
        .REFERENCECLK(clk), .RESET(rst_n), .cfg(b_if),
        .ENABLE(en_b), .STROBE(b_strobe), .CLKOUT(b_clkout), .LOCK(b_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       m_acc[2];
    int       m_inc[2];
    bit [1:0] m_strobe;
    bit [1:0] m_clk;
    int       m_state;
    int       m_cnt;
    int       m_chan;
    int       m_linc;
    logic [5:0] exp_q[$];

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model of channel A, advanced once per rising edge from the pre-edge inputs.
    task automatic model_step();
        int sum;
        int apply_ch;
        if (!rst_n) begin
            m_acc[0] = 0; m_acc[1] = 0;
            m_inc[0] = 'h80; m_inc[1] = 'h40;
            m_strobe = '0; m_clk = '0;
            m_state = M_SETTLE; m_cnt = 0;
        end else begin
            apply_ch = (m_state == M_APPLY && m_chan < 2) ? m_chan : -1;
            for (int c = 0; c < 2; c++) begin
                if (c == apply_ch) begin
                    m_inc[c] = m_linc; m_acc[c] = 0; m_strobe[c] = 1'b0; m_clk[c] = 1'b0;
                end else if (en_a[c]) begin
                    sum = m_acc[c] + m_inc[c];
                    m_strobe[c] = (sum > 255);
                    m_acc[c] = sum % 256;
                    m_clk[c] = (m_acc[c] >= 128);
                end else begin
                    m_acc[c] = 0; m_strobe[c] = 1'b0; m_clk[c] = 1'b0;
                end
            end
            case (m_state)
                M_SETTLE: begin
                    m_cnt++;
                    if (m_cnt == 4) begin m_state = M_IDLE; m_cnt = 0; end
                end
                M_IDLE: begin
                    if (a_if.CFG_VALID) begin
                        m_chan = int'(a_if.CFG_CHAN);
                        m_linc = int'(a_if.CFG_INC);
                        m_state = M_APPLY;
                    end
                end
                default: begin
                    m_state = (m_chan < 2) ? M_SETTLE : M_IDLE;
                    m_cnt = 0;
                end
            endcase
        end
    endtask

    task automatic apply_stimulus();
        logic [5:0] got;
        @(posedge clk);
        model_step();
        exp_q.push_back({m_strobe, m_clk, m_state == M_IDLE, m_state == M_IDLE});
        #1;
        got = {a_strobe, a_clkout, a_if.CFG_READY, a_lock};
        check_output("scoreboard", 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic do_cfg(input int chan, input int inc);
        bit accepted = 0;
        bit idle_now;
        a_if.CFG_VALID = 1'b1;
        a_if.CFG_CHAN  = chan[0];
        a_if.CFG_INC   = inc[7:0];
        for (int i = 0; i < 40 && !accepted; i++) begin
            idle_now = (m_state == M_IDLE);
            apply_stimulus();
            if (idle_now) accepted = 1;
        end
        a_if.CFG_VALID = 1'b0;
        check_output("cfg_accept", 32'(accepted), 32'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !a_if.CFG_READY; i++) apply_stimulus();
        check_output("ready_wait", 32'(a_if.CFG_READY), 32'd1);
    endtask

    initial begin
        int first, lock_at, cnt0, hi1, consec, rl, ll, cnt2;
        bit prev;
        rst_n = 1'b0; en_a = 2'b00; en_b = 3'b111;
        a_if.CFG_VALID = 1'b0; a_if.CFG_CHAN = '0; a_if.CFG_INC = '0;
        b_if.CFG_VALID = 1'b0; b_if.CFG_CHAN = '0; b_if.CFG_INC = '0;
        repeat (3) apply_stimulus();

        // Release reset with both channels running at their default ratios.
        rst_n = 1'b1; en_a = 2'b11;
        first = -1; lock_at = -1; cnt0 = 0; hi1 = 0;
        for (int i = 1; i <= 12; i++) begin
            apply_stimulus();
            if (a_strobe[1] && first < 0) first = i;
            if (a_lock && lock_at < 0) lock_at = i;
            cnt0 += int'(a_strobe[0]);
            hi1  += int'(a_clkout[1]);
        end
        check_output("ch1_first_strobe", 32'(first), 32'd4);
        check_output("lock_after_reset", 32'(lock_at), 32'd4);
        check_output("ch0_strobes_12", 32'(cnt0), 32'd6);
        check_output("ch1_clkout_duty", 32'(hi1), 32'd6);

        // Fractional ratio 85/256 over three full accumulator periods.
        do_cfg(0, 'h55);
        apply_stimulus();
        cnt0 = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 768; i++) begin
            apply_stimulus();
            if (a_strobe[0] && prev) consec++;
            cnt0 += int'(a_strobe[0]);
            prev = a_strobe[0];
        end
        check_output("ch0_frac_count", 32'(cnt0), 32'd255);
        check_output("ch0_no_back2back", 32'(consec), 32'd0);

        // Retune ch1 while ch0 keeps running.
        do_cfg(1, 'h20);
        rl = int'(!a_if.CFG_READY); ll = int'(!a_lock);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus();
            if (a_if.CFG_READY && a_lock) break;
            rl += int'(!a_if.CFG_READY);
            ll += int'(!a_lock);
        end
        check_output("ready_low_cycles", 32'(rl), 32'd5);
        check_output("lock_low_cycles", 32'(ll), 32'd5);
        hi1 = 0;
        for (int i = 0; i < 32; i++) begin
            apply_stimulus();
            hi1 += int'(a_strobe[1]);
        end
        check_output("ch1_period8", 32'(hi1), 32'd4);

        // Out-of-range channel on the three-channel instance.
        b_if.CFG_VALID = 1'b1; b_if.CFG_CHAN = 2'd3; b_if.CFG_INC = 8'h11;
        apply_stimulus();
        b_if.CFG_VALID = 1'b0;
        rl = int'(!b_if.CFG_READY); ll = int'(!b_lock);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus();
            if (b_if.CFG_READY && b_lock) break;
            rl += int'(!b_if.CFG_READY);
            ll += int'(!b_lock);
        end
        check_output("oor_ready_low", 32'(rl), 32'd1);
        check_output("oor_lock_low", 32'(ll), 32'd1);
        cnt0 = 0; cnt2 = 0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus();
            cnt0 += int'(b_strobe[0]);
            cnt2 += int'(b_strobe[2]);
        end
        check_output("oor_ch0_unchanged", 32'(cnt0), 32'd8);
        check_output("oor_ch2_unchanged", 32'(cnt2), 32'd2);

        // Reset in the middle of a settle discards the retune.
        do_cfg(0, 'h10);
        apply_stimulus();
        apply_stimulus();
        rst_n = 1'b0;
        apply_stimulus();
        apply_stimulus();
        check_output("reset_outputs", 32'({a_strobe, a_clkout, a_lock}), 32'd0);
        rst_n = 1'b1;
        lock_at = -1;
        for (int i = 1; i <= 20 && lock_at < 0; i++) begin
            apply_stimulus();
            if (a_lock) lock_at = i;
        end
        check_output("lock_after_rereset", 32'(lock_at), 32'd4);
        cnt0 = 0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus();
            cnt0 += int'(a_strobe[0]);
        end
        check_output("ch0_default_restored", 32'(cnt0), 32'd4);

        // Zero increment with the enable toggling, then restart at half rate.
        do_cfg(1, 'h00);
        wait_ready();
        hi1 = 0;
        for (int i = 0; i < 10; i++) begin
            en_a[1] = ~en_a[1];
            apply_stimulus();
            hi1 += int'(a_strobe[1]) + int'(a_clkout[1]);
        end
        check_output("inc0_quiet", 32'(hi1), 32'd0);
        en_a[1] = 1'b0;
        do_cfg(1, 'h80);
        wait_ready();
        en_a[1] = 1'b1;
        first = -1;
        for (int i = 1; i <= 6; i++) begin
            apply_stimulus();
            if (a_strobe[1] && first < 0) first = i;
        end
        check_output("reenable_first_strobe", 32'(first), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
